// File: rtl/jtvigil_romarb.sv
// jtvigil_romarb: shares one SDRAM bank between the main CPU, sound CPU and
// ADPCM byte-wide ROM ports. Each requester keeps its last fetched 16-bit
// word so repeat accesses to the same word are served without SDRAM traffic.
module jtvigil_romarb #(
    parameter int          MAIN_AW     = 18,
    parameter int          SND_AW      = 15,
    parameter int          PCM_AW      = 17,
    parameter logic [21:0] MAIN_OFFSET = 22'h00_0000,
    parameter logic [21:0] SND_OFFSET  = 22'h02_0000,
    parameter logic [21:0] PCM_OFFSET  = 22'h03_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               downloading,
    input  logic               main_cs,
    input  logic [MAIN_AW-1:0] main_addr,
    output logic [7:0]         main_data,
    output logic               main_ok,
    input  logic               snd_cs,
    input  logic [SND_AW-1:0]  snd_addr,
    output logic [7:0]         snd_data,
    output logic               snd_ok,
    input  logic               pcm_cs,
    input  logic [PCM_AW-1:0]  pcm_addr,
    output logic [7:0]         pcm_data,
    output logic               pcm_ok,
    output logic [21:0]        ba_addr,
    output logic               ba_rd,
    input  logic               ba_ack,
    input  logic               ba_rdy,
    input  logic [15:0]        data_read
);

    // Latched word address is as wide as the widest requester word address.
    localparam int LA_W = ((MAIN_AW > SND_AW) ? ((MAIN_AW > PCM_AW) ? MAIN_AW : PCM_AW)
                                              : ((SND_AW > PCM_AW) ? SND_AW : PCM_AW)) - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [1:0] ID_MAIN = 2'd0;
    localparam logic [1:0] ID_SND  = 2'd1;
    localparam logic [1:0] ID_PCM  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        r_gnt;
    logic [1:0]        r_last;
    logic [LA_W-1:0]   r_la;
    logic [21:0]       r_ba_addr;
    logic              r_ba_rd;

    logic [2:0]        r_cv;
    logic [MAIN_AW-2:0] r_main_cw;
    logic [SND_AW-2:0]  r_snd_cw;
    logic [PCM_AW-2:0]  r_pcm_cw;
    logic [15:0]       r_main_cd;
    logic [15:0]       r_snd_cd;
    logic [15:0]       r_pcm_cd;

    logic              w_main_hit;
    logic              w_snd_hit;
    logic              w_pcm_hit;
    logic [2:0]        w_pend;
    logic [LA_W-1:0]   w_main_la;
    logic [LA_W-1:0]   w_snd_la;
    logic [LA_W-1:0]   w_pcm_la;
    logic              w_sel_vld;
    logic [1:0]        w_sel;
    logic [LA_W-1:0]   w_sel_la;
    logic [21:0]       w_sel_off;
    logic              w_capture;

    assign w_main_la = LA_W'(main_addr[MAIN_AW-1:1]);
    assign w_snd_la  = LA_W'(snd_addr[SND_AW-1:1]);
    assign w_pcm_la  = LA_W'(pcm_addr[PCM_AW-1:1]);

    assign w_main_hit = main_cs & r_cv[0] & (r_main_cw == main_addr[MAIN_AW-1:1]);
    assign w_snd_hit  = snd_cs  & r_cv[1] & (r_snd_cw  == snd_addr[SND_AW-1:1]);
    assign w_pcm_hit  = pcm_cs  & r_cv[2] & (r_pcm_cw  == pcm_addr[PCM_AW-1:1]);

    assign w_pend = {pcm_cs  & ~w_pcm_hit,
                     snd_cs  & ~w_snd_hit,
                     main_cs & ~w_main_hit} & {3{~downloading}};

    assign main_ok  = w_main_hit & ~downloading;
    assign snd_ok   = w_snd_hit  & ~downloading;
    assign pcm_ok   = w_pcm_hit  & ~downloading;
    assign main_data = main_addr[0] ? r_main_cd[15:8] : r_main_cd[7:0];
    assign snd_data  = snd_addr[0]  ? r_snd_cd[15:8]  : r_snd_cd[7:0];
    assign pcm_data  = pcm_addr[0]  ? r_pcm_cd[15:8]  : r_pcm_cd[7:0];

    assign ba_addr = r_ba_addr;
    assign ba_rd   = r_ba_rd;

    // A word lands either in DATA, or in REQ when ack and rdy coincide.
    assign w_capture = ((r_state == ST_REQ) & ba_ack & ba_rdy) |
                       ((r_state == ST_DATA) & ba_rdy);

    // Round-robin pick: first pending requester after the last granted one.
    always_comb begin
        w_sel_vld = |w_pend;
        w_sel     = ID_MAIN;
        case (r_last)
            ID_MAIN: w_sel = w_pend[1] ? ID_SND  : (w_pend[2] ? ID_PCM  : ID_MAIN);
            ID_SND:  w_sel = w_pend[2] ? ID_PCM  : (w_pend[0] ? ID_MAIN : ID_SND);
            default: w_sel = w_pend[0] ? ID_MAIN : (w_pend[1] ? ID_SND  : ID_PCM);
        endcase
        case (w_sel)
            ID_MAIN: begin w_sel_la = w_main_la; w_sel_off = MAIN_OFFSET; end
            ID_SND:  begin w_sel_la = w_snd_la;  w_sel_off = SND_OFFSET;  end
            default: begin w_sel_la = w_pcm_la;  w_sel_off = PCM_OFFSET;  end
        endcase
    end

    // Bus FSM: grant from IDLE, hold the request until ack, wait for data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= ID_MAIN;
            r_la      <= '0;
            r_ba_addr <= '0;
            r_ba_rd   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_vld) begin
                        r_gnt     <= w_sel;
                        r_la      <= w_sel_la;
                        r_ba_addr <= w_sel_off + 22'(w_sel_la);
                        r_ba_rd   <= 1'b1;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ba_ack) begin
                        r_ba_rd <= 1'b0;
                        r_state <= ba_rdy ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (ba_rdy) r_state <= ST_IDLE;
                end
                default: begin
                    r_ba_rd <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Word cache: store the fetched word; a download invalidates everything,
    // including a word that lands while the download is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cv      <= 3'b000;
            r_last    <= ID_PCM;
            r_main_cw <= '0;
            r_snd_cw  <= '0;
            r_pcm_cw  <= '0;
            r_main_cd <= '0;
            r_snd_cd  <= '0;
            r_pcm_cd  <= '0;
        end else begin
            if (w_capture) begin
                r_last <= r_gnt;
                case (r_gnt)
                    ID_MAIN: begin r_main_cd <= data_read; r_main_cw <= r_la[MAIN_AW-2:0]; end
                    ID_SND:  begin r_snd_cd  <= data_read; r_snd_cw  <= r_la[SND_AW-2:0];  end
                    default: begin r_pcm_cd  <= data_read; r_pcm_cw  <= r_la[PCM_AW-2:0];  end
                endcase
            end
            if (downloading) begin
                r_cv <= 3'b000;
            end else if (w_capture) begin
                case (r_gnt)
                    ID_MAIN: r_cv[0] <= 1'b1;
                    ID_SND:  r_cv[1] <= 1'b1;
                    default: r_cv[2] <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtvigil_romarb.sv
// Testbench for jtvigil_romarb: directed scenarios plus randomized traffic
// from all three requesters against an SDRAM memory model and scoreboard.
module tb_jtvigil_romarb;

    logic        clk = 1'b0;
    logic        rst, downloading;
    logic        main_cs, snd_cs, pcm_cs;
    logic [17:0] main_addr;
    logic [14:0] snd_addr;
    logic [16:0] pcm_addr;
    logic [7:0]  main_data, snd_data, pcm_data;
    logic        main_ok, snd_ok, pcm_ok;
    logic [21:0] ba_addr;
    logic        ba_rd, ba_ack, ba_rdy;
    logic [15:0] data_read;

    int checks = 0;
    int failures = 0;
    int exp_fetches = 0;
    bit sd_auto = 1'b0;

    logic [21:0] fetch_log[$];
    logic [7:0]  sb_main[$];
    logic [7:0]  sb_snd[$];
    logic [7:0]  sb_pcm[$];

    always #5 clk = ~clk;

    jtvigil_romarb dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .main_cs(main_cs), .main_addr(main_addr), .main_data(main_data), .main_ok(main_ok),
        .snd_cs(snd_cs), .snd_addr(snd_addr), .snd_data(snd_data), .snd_ok(snd_ok),
        .pcm_cs(pcm_cs), .pcm_addr(pcm_addr), .pcm_data(pcm_data), .pcm_ok(pcm_ok),
        .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_rdy(ba_rdy),
        .data_read(data_read)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // SDRAM content: arbitrary but deterministic function of the word address.
    function automatic logic [15:0] mem_word(input logic [21:0] a);
        logic [15:0] h;
        h = a[15:0] * 16'h9E37;
        return h ^ {a[21:16], 10'h155};
    endfunction

    // Expected byte: ROM base + byte address / 2 selects the word, bit 0 the byte.
    function automatic logic [7:0] exp_byte(input int who, input logic [17:0] addr);
        logic [21:0] base;
        logic [15:0] w;
        base = (who == 0) ? 22'h000000 : (who == 1) ? 22'h020000 : 22'h030000;
        w = mem_word(base + {5'b0, addr[17:1]});
        return addr[0] ? w[15:8] : w[7:0];
    endfunction

    function automatic int sb_size(input int who);
        if (who == 0) return sb_main.size();
        if (who == 1) return sb_snd.size();
        return sb_pcm.size();
    endfunction

    task automatic sb_push(input int who, input logic [7:0] b);
        if (who == 0) sb_main.push_back(b);
        else if (who == 1) sb_snd.push_back(b);
        else sb_pcm.push_back(b);
    endtask

    task automatic sb_flush(input int who);
        if (who == 0) sb_main.delete();
        else if (who == 1) sb_snd.delete();
        else sb_pcm.delete();
    endtask

    task automatic drive_req(input int who, input logic cs, input logic [17:0] a);
        if (who == 0) begin main_cs = cs; main_addr = a; end
        else if (who == 1) begin snd_cs = cs; snd_addr = a[14:0]; end
        else begin pcm_cs = cs; pcm_addr = a[16:0]; end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; main_cs = 1'b0; snd_cs = 1'b0; pcm_cs = 1'b0;
        downloading = 1'b0; ba_ack = 1'b0; ba_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_all(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (!(main_ok && snd_ok && pcm_ok) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check(name, {29'b0, main_ok, snd_ok, pcm_ok}, 32'h7);
    endtask

    // Monitor: whenever a requester reports ok with an outstanding expectation,
    // pop and compare the byte it presents.
    always @(negedge clk) begin
        logic [7:0] e;
        if (main_ok && sb_main.size() > 0) begin e = sb_main.pop_front(); check("sb_main_data", main_data, e); end
        if (snd_ok  && sb_snd.size()  > 0) begin e = sb_snd.pop_front();  check("sb_snd_data",  snd_data,  e); end
        if (pcm_ok  && sb_pcm.size()  > 0) begin e = sb_pcm.pop_front();  check("sb_pcm_data",  pcm_data,  e); end
    end

    // Automatic SDRAM responder: random ack delay, sometimes ack+rdy together.
    initial begin
        logic [21:0] a;
        bit          same;
        forever begin
            @(negedge clk);
            if (sd_auto && ba_rd === 1'b1) begin
                a = ba_addr;
                repeat ($urandom_range(0, 3) + 1) tick();
                check("req_hold", {9'b0, ba_rd, ba_addr}, {9'b0, 1'b1, a});
                ba_ack = 1'b1;
                same = ($urandom_range(0, 3) == 0);
                if (same) begin ba_rdy = 1'b1; data_read = mem_word(a); end
                tick();
                ba_ack = 1'b0; ba_rdy = 1'b0; data_read = 16'($urandom);
                if (!same) begin
                    repeat ($urandom_range(0, 3)) tick();
                    ba_rdy = 1'b1; data_read = mem_word(a);
                    tick();
                    ba_rdy = 1'b0; data_read = 16'($urandom);
                end
                fetch_log.push_back(a);
            end
        end
    end

    // Random requester: only the word of its last served request is cached.
    task automatic rand_driver(input int who, input int n);
        logic [17:0] a;
        logic [16:0] lastw;
        bit          lastv;
        int          t;
        lastv = 1'b0;
        lastw = '0;
        for (int i = 0; i < n; i++) begin
            a = 18'($urandom_range(0, 11));
            tick();
            drive_req(who, 1'b1, a);
            if (!(lastv && lastw == a[17:1])) exp_fetches++;
            lastv = 1'b1;
            lastw = a[17:1];
            sb_push(who, exp_byte(who, a));
            t = 0;
            while (sb_size(who) > 0 && t < 300) begin @(posedge clk); t++; end
            if (sb_size(who) > 0) begin
                check("rand_timeout", 32'(sb_size(who)), 32'h0);
                sb_flush(who);
            end
            if ($urandom_range(0, 2) == 0) begin
                tick();
                drive_req(who, 1'b0, a);
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end
        tick();
        drive_req(who, 1'b0, 18'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; downloading = 1'b0;
        main_cs = 1'b0; snd_cs = 1'b0; pcm_cs = 1'b0;
        main_addr = '0; snd_addr = '0; pcm_addr = '0;
        ba_ack = 1'b0; ba_rdy = 1'b0; data_read = '0;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_ok", {29'b0, main_ok, snd_ok, pcm_ok}, 32'h0);
        check("rst_ba_rd", ba_rd, 1'b0);
        check("rst_ba_addr", ba_addr, 22'h0);
        check("rst_data", {main_data, snd_data, pcm_data}, 24'h0);

        // Main miss, then same-word hit on the other byte
        tick(); main_cs = 1'b1; main_addr = 18'h00010;
        @(negedge clk); check("main_c0_rd", ba_rd, 1'b0);
        tick(); @(negedge clk);
        check("main_rd", ba_rd, 1'b1);
        check("main_ba_addr", ba_addr, 22'h000008);
        tick(); @(negedge clk); check("main_rd_hold", ba_rd, 1'b1);
        tick(); ba_ack = 1'b1; @(negedge clk); check("main_rd_ack", ba_rd, 1'b1);
        tick(); ba_ack = 1'b0; @(negedge clk);
        check("main_rd_drop", ba_rd, 1'b0);
        check("main_ok_wait", main_ok, 1'b0);
        tick(); ba_rdy = 1'b1; data_read = 16'hBEEF; @(negedge clk);
        check("main_ok_rdy", main_ok, 1'b0);
        tick(); ba_rdy = 1'b0; data_read = 16'h0; @(negedge clk);
        check("main_ok", main_ok, 1'b1);
        check("main_data_lo", main_data, 8'hEF);
        tick(); main_addr = 18'h00011; @(negedge clk);
        check("main_hit_ok", main_ok, 1'b1);
        check("main_data_hi", main_data, 8'hBE);
        check("main_hit_nord", ba_rd, 1'b0);
        tick(); @(negedge clk); check("main_hit_nord2", ba_rd, 1'b0);

        // Sound miss with ack and rdy in the same cycle
        tick(); snd_cs = 1'b1; snd_addr = 15'h0002;
        tick(); @(negedge clk);
        check("snd_rd", ba_rd, 1'b1);
        check("snd_ba_addr", ba_addr, 22'h020001);
        check("snd_ok_wait", snd_ok, 1'b0);
        check("main_kept", {main_ok, main_data}, {1'b1, 8'hBE});
        tick(); ba_ack = 1'b1; ba_rdy = 1'b1; data_read = 16'h1234; @(negedge clk);
        check("snd_ok_rdy", snd_ok, 1'b0);
        tick(); ba_ack = 1'b0; ba_rdy = 1'b0; data_read = 16'h0; @(negedge clk);
        check("snd_ok", {snd_ok, snd_data}, {1'b1, 8'h34});
        check("snd_idle", ba_rd, 1'b0);
        tick(); snd_addr = 15'h0003; @(negedge clk);
        check("snd_data_hi", {snd_ok, snd_data}, {1'b1, 8'h12});
        check("snd_no_refetch", ba_rd, 1'b0);
        tick(); main_cs = 1'b0; snd_cs = 1'b0;

        // Round-robin with all three pending
        do_reset();
        sd_auto = 1'b1;
        fetch_log.delete();
        tick();
        main_cs = 1'b1; main_addr = 18'h20;
        snd_cs  = 1'b1; snd_addr  = 15'h30;
        pcm_cs  = 1'b1; pcm_addr  = 17'h40;
        wait_all("rr1_all_ok");
        check("rr1_count", 32'(fetch_log.size()), 32'd3);
        check("rr1_g0", fetch_log[0], 22'h000010);
        check("rr1_g1", fetch_log[1], 22'h020018);
        check("rr1_g2", fetch_log[2], 22'h030020);
        tick();
        main_addr = 18'h22; snd_addr = 15'h32; pcm_addr = 17'h43;
        wait_all("rr2_all_ok");
        check("rr2_count", 32'(fetch_log.size()), 32'd6);
        check("rr2_g0", fetch_log[3], 22'h000011);
        check("rr2_g1", fetch_log[4], 22'h020019);
        check("rr2_g2", fetch_log[5], 22'h030021);
        check("rr2_main_data", main_data, exp_byte(0, 18'h22));
        check("rr2_pcm_data", pcm_data, exp_byte(2, 18'h43));
        tick(); main_cs = 1'b0; snd_cs = 1'b0; pcm_cs = 1'b0;
        repeat (4) tick();
        sd_auto = 1'b0;

        // ADPCM address changes while the fetch is in DATA
        do_reset();
        tick(); pcm_cs = 1'b1; pcm_addr = 17'h00100;
        tick(); @(negedge clk);
        check("pcm_ba_addr1", {9'b0, ba_rd, ba_addr}, {9'b0, 1'b1, 22'h030080});
        tick(); ba_ack = 1'b1;
        tick(); ba_ack = 1'b0; pcm_addr = 17'h00200;
        tick(); ba_rdy = 1'b1; data_read = 16'hA55A; @(negedge clk);
        check("pcm_ok_rdy", pcm_ok, 1'b0);
        tick(); ba_rdy = 1'b0; @(negedge clk);
        check("pcm_stale_ok", pcm_ok, 1'b0);
        check("pcm_idle_gap", ba_rd, 1'b0);
        tick(); @(negedge clk);
        check("pcm_ba_addr2", {9'b0, ba_rd, ba_addr}, {9'b0, 1'b1, 22'h030100});
        tick(); pcm_addr = 17'h00100; @(negedge clk);
        check("pcm_old_word", {pcm_ok, pcm_data}, {1'b1, 8'h5A});
        tick(); pcm_addr = 17'h00201; ba_ack = 1'b1; ba_rdy = 1'b1; data_read = 16'hC3D4; @(negedge clk);
        check("pcm_miss2", pcm_ok, 1'b0);
        tick(); ba_ack = 1'b0; ba_rdy = 1'b0; @(negedge clk);
        check("pcm_new_word", {pcm_ok, pcm_data}, {1'b1, 8'hC3});
        tick(); pcm_cs = 1'b0;

        // Download starts during DATA
        do_reset();
        tick(); main_cs = 1'b1; main_addr = 18'h00040;
        tick(); @(negedge clk);
        check("dl_ba_addr", {9'b0, ba_rd, ba_addr}, {9'b0, 1'b1, 22'h000020});
        tick(); ba_ack = 1'b1;
        tick(); ba_ack = 1'b0; downloading = 1'b1;
        tick(); ba_rdy = 1'b1; data_read = 16'h7777; @(negedge clk);
        check("dl_ok_rdy", main_ok, 1'b0);
        tick(); ba_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("dl_quiet", {30'b0, main_ok, ba_rd}, 32'h0);
            tick();
        end
        downloading = 1'b0; @(negedge clk);
        check("dl_end_ok", {30'b0, main_ok, ba_rd}, 32'h0);
        tick(); @(negedge clk);
        check("dl_refetch", {9'b0, ba_rd, ba_addr}, {9'b0, 1'b1, 22'h000020});

        // Reset while a request is outstanding
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; main_cs = 1'b0; @(negedge clk);
        check("rst_req_rd", ba_rd, 1'b0);
        check("rst_req_ok", {29'b0, main_ok, snd_ok, pcm_ok}, 32'h0);

        // Randomized concurrent traffic against the scoreboard
        do_reset();
        sd_auto = 1'b1;
        fetch_log.delete();
        exp_fetches = 0;
        fork
            rand_driver(0, 40);
            rand_driver(1, 40);
            rand_driver(2, 40);
        join
        repeat (20) @(posedge clk);
        check("rand_fetch_count", 32'(fetch_log.size()), 32'(exp_fetches));
        check("rand_sb_drained", 32'(sb_main.size() + sb_snd.size() + sb_pcm.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtvigil_romarb.md
Name: jtvigil_romarb

Overview:
- Read-slot arbiter and per-requester word cache.
- Shares one SDRAM bank between three byte-wide ROM requesters: main CPU ROM, sound CPU ROM and ADPCM ROM.
- Sits between jtvigil_main / jtvigil_snd and the bank-0 port of the SDRAM controller, inside jtvigil_sdram.
- Converts byte requests into 16-bit word reads, holds the last word per requester, and serves repeat hits without SDRAM traffic.

Parameters:
- MAIN_AW, 18, main ROM byte-address width
- SND_AW, 15, sound ROM byte-address width
- PCM_AW, 17, ADPCM ROM byte-address width
- MAIN_OFFSET, 22'h00_0000, SDRAM word offset of main ROM
- SND_OFFSET, 22'h02_0000, SDRAM word offset of sound ROM
- PCM_OFFSET, 22'h03_0000, SDRAM word offset of ADPCM ROM

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- downloading  in  1  ROM load in progress
- main_cs  in  1  main ROM request
- main_addr  in  MAIN_AW  main byte address
- main_data  out  8  main read byte
- main_ok  out  1  main_data valid for main_addr
- snd_cs  in  1  sound ROM request
- snd_addr  in  SND_AW  sound byte address
- snd_data  out  8  sound read byte
- snd_ok  out  1  snd_data valid for snd_addr
- pcm_cs  in  1  ADPCM ROM request
- pcm_addr  in  PCM_AW  ADPCM byte address
- pcm_data  out  8  ADPCM read byte
- pcm_ok  out  1  pcm_data valid for pcm_addr
- ba_addr  out  22  SDRAM word address
- ba_rd  out  1  SDRAM read request
- ba_ack  in  1  request accepted
- ba_rdy  in  1  data_read valid, one-cycle pulse
- data_read  in  16  SDRAM read word

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high.
- Reset values:
  - ba_rd=0, ba_addr=0, state=IDLE.
  - All cache valid bits=0, so every *_ok=0.
  - Round-robin "last granted" = PCM, so main is checked first.
  - *_data outputs=0.
- Per-requester cache: word address cw, data cd[15:0], valid cv.
  - hit_x = cs_x & cv_x & (cw_x == addr_x[AW-1:1]); combinational.
  - ok_x = hit_x & ~downloading.
  - data_x = addr_x[0] ? cd_x[15:8] : cd_x[7:0]; combinational.
- pend_x = cs_x & ~hit_x & ~downloading.
- FSM:
  - IDLE: if any pend, pick the first pending requester after the last granted one (order main→snd→pcm→main). Register grant id, latched word address la = addr[AW-1:1], ba_addr = OFFSET_x + la (22-bit, wraps modulo 2^22), ba_rd=1. Go REQ.
  - REQ: hold ba_rd and ba_addr stable until ba_ack. On ack, ba_rd←0 and go DATA. If ba_ack and ba_rdy arrive in the same cycle, treat as ack followed by capture and go straight to IDLE.
  - DATA: on ba_rdy, cd_g←data_read, cw_g←la, cv_g←1, last-granted←g. Go IDLE.
  - ba_rdy while in IDLE, or in REQ without ba_ack, is ignored.
- Latency on a miss with idle bus:
  - cs/addr change at cycle 0 → ba_rd=1 at cycle 1.
  - ok asserts in the cycle after ba_rdy.
  - A hit gives ok in the same cycle (0 wait).
- Address change during a transaction:
  - The fetch completes with the latched address and updates the cache.
  - hit then fails and a new request is issued from IDLE.
- cs dropped mid-transaction: the transaction completes normally; the SDRAM read is never aborted.
- downloading=1:
  - All cv cleared every cycle; ok low; no new grants.
  - An in-flight REQ/DATA completes, but its captured data is not marked valid.
- Simultaneous pend on all three: strict rotation. No requester waits more than two other transactions.
- A new grant is issued only from IDLE. There is always at least one idle cycle between transactions.

Test Plan:
- Reset, then main_cs=1, main_addr=18'h00010, SDRAM returns 16'hBEEF → ba_addr=22'h000008, ba_rd high until ack. main_ok rises the cycle after ba_rdy; main_data=8'hEF. Change addr to 18'h00011 → main_data=8'hBE same cycle, no new ba_rd.
- snd_cs=1, snd_addr=15'h0002 → ba_addr=22'h020001; snd_ok=0 until ba_rdy; main cache unaffected.
- main, snd and pcm all pending from reset → grants issued in order main, snd, pcm. Re-request all → order continues main, snd, pcm.
- pcm_addr changed from 17'h00100 to 17'h00200 while in DATA → first fetch completes (cw=0x80), pcm_ok stays low, second ba_addr=22'h030100 issued.
- ba_ack and ba_rdy in the same cycle with data 16'h1234 → captured, state IDLE next cycle, ok asserted.
- downloading=1 mid-DATA → ok never asserts, cv=0 after completion, no further ba_rd until downloading=0. rst pulse in REQ → ba_rd=0 next cycle, all ok low.
